vga_frame_sequencer: RTL

//  Sequences the 640x480@60 raster for the Pong display. Derives a 25 MHz pixel enable from the 100 MHz

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_frame_sequencer_if.sv | 29 ++
 rtl/wrap_counter.sv | 27 ++
 rtl/vga_frame_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing and shared types for the Pong frame sequencer.
package vga_timing_pkg;

  localparam int unsigned CLK_DIV_DEF   = 4;
  localparam int unsigned COUNT_W       = 10;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;
  localparam int unsigned V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned HS_START_DEF  = H_VISIBLE_DEF + H_FP_DEF;
  localparam int unsigned HS_END_DEF    = HS_START_DEF + H_SYNC_DEF;
  localparam int unsigned VS_START_DEF  = V_VISIBLE_DEF + V_FP_DEF;
  localparam int unsigned VS_END_DEF    = VS_START_DEF + V_SYNC_DEF;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    GRANT
  } upd_state_t;

endpackage

// File: rtl/vga_frame_sequencer_if.sv
// Raster timing outputs plus the game-logic update handshake of the frame sequencer.
interface vga_frame_sequencer_if;
  import vga_timing_pkg::*;

  logic               pix_en;
  logic [COUNT_W-1:0] h_count;
  logic [COUNT_W-1:0] v_count;
  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic               line_tick;
  logic               frame_tick;
  logic               upd_req;
  logic               upd_done;
  logic               upd_grant;

  modport master (
    output pix_en, h_count, v_count, hsync, vsync, video_on,
           line_tick, frame_tick, upd_grant,
    input  upd_req, upd_done
  );

  modport slave (
    input  pix_en, h_count, v_count, hsync, vsync, video_on,
           line_tick, frame_tick, upd_grant,
    output upd_req, upd_done
  );

endinterface

// File: rtl/wrap_counter.sv
// Modulo counter: steps on en, wraps MAX->0; wrap flags the step that returns to 0.
module wrap_counter #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned MAX   = 799
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_frame_sequencer.sv
// Raster sequencer: pixel enable, h/v counters, registered sync/video decode and vblank update grant.
module vga_frame_sequencer
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter bit          SYNC_POL  = 1'b0
) (
  input logic                   clk,
  input logic                   rst,
  vga_frame_sequencer_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [COUNT_W-1:0] HS_START = COUNT_W'(H_VISIBLE + H_FP);
  localparam logic [COUNT_W-1:0] HS_END   = COUNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [COUNT_W-1:0] VS_START = COUNT_W'(V_VISIBLE + V_FP);
  localparam logic [COUNT_W-1:0] VS_END   = COUNT_W'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [COUNT_W-1:0] H_VIS    = COUNT_W'(H_VISIBLE);
  localparam logic [COUNT_W-1:0] V_VIS    = COUNT_W'(V_VISIBLE);
  localparam logic [COUNT_W-1:0] V_ENTRY  = COUNT_W'(V_VISIBLE - 1);

  logic [DIV_W-1:0]   div;
  logic               unused_div;
  logic               pix_en;
  logic               h_wrap;
  logic               v_wrap;
  logic [COUNT_W-1:0] h_count;
  logic [COUNT_W-1:0] v_count;
  logic [COUNT_W-1:0] h_next;
  logic [COUNT_W-1:0] v_next;
  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic               line_tick;
  logic               frame_tick;
  logic               vblank_entry;
  upd_state_t         state;
  upd_state_t         state_next;

  assign unused_div = ^div;

  wrap_counter #(.WIDTH(DIV_W), .MAX(CLK_DIV - 1)) u_div (
    .clk(clk), .clr(rst), .en(1'b1), .count(div), .wrap(pix_en)
  );

  wrap_counter #(.WIDTH(COUNT_W), .MAX(H_TOTAL - 1)) u_h (
    .clk(clk), .clr(rst), .en(pix_en), .count(h_count), .wrap(h_wrap)
  );

  wrap_counter #(.WIDTH(COUNT_W), .MAX(V_TOTAL - 1)) u_v (
    .clk(clk), .clr(rst), .en(h_wrap), .count(v_count), .wrap(v_wrap)
  );

  // Decode looks at the counts the counters are about to load, so it lands with them.
  always_comb begin
    h_next = h_wrap ? '0 : h_count + 1'b1;
    v_next = v_count;
    if (v_wrap) begin
      v_next = '0;
    end else if (h_wrap) begin
      v_next = v_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      video_on   <= 1'b0;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      line_tick  <= h_wrap;
      frame_tick <= v_wrap;
      if (pix_en) begin
        hsync    <= (h_next >= HS_START && h_next < HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync    <= (v_next >= VS_START && v_next < VS_END) ? SYNC_POL : ~SYNC_POL;
        video_on <= (h_next < H_VIS) && (v_next < V_VIS);
      end
    end
  end

  assign vblank_entry = h_wrap && (v_count == V_ENTRY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The grant closes on the frame-wrap step itself, so it is already low when frame_tick shows.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (vga.upd_req) state_next = ARMED;
      end
      ARMED: begin
        if (!vga.upd_req)     state_next = IDLE;
        else if (vblank_entry) state_next = GRANT;
      end
      GRANT: begin
        if (vga.upd_done || v_wrap) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign vga.pix_en     = pix_en;
  assign vga.h_count    = h_count;
  assign vga.v_count    = v_count;
  assign vga.hsync      = hsync;
  assign vga.vsync      = vsync;
  assign vga.video_on   = video_on;
  assign vga.line_tick  = line_tick;
  assign vga.frame_tick = frame_tick;
  assign vga.upd_grant  = (state == GRANT);

endmodule
